px_scan_buffer: RTL

Pixel scan sequencer and result buffer between the pixel-oscillator counter and the I2C register path. It steps through the pixels in turn and, for each one, clears the shared 32-bit counter, enables that pixel's oscillator for a programmed window, then freezes it. The frozen count is captured into a small FIFO, and the I2C side drains one 32-bit word per read acknowledge.

---
 rtl/px_scan_buffer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/px_scan_buffer.sv
// Pixel scan sequencer with result FIFO.
// Steps through NPIX pixels: clear the shared counter, open one oscillator for a
// programmed window, let the count settle, then capture it into a FIFO that the
// I2C side drains one word per rd_ack.
// Optional macro PX_TAG_EN: tag each captured word with its pixel index.
module px_scan_buffer #(
  parameter int unsigned NPIX       = 24,
  parameter int unsigned WIN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIN_W-1:0]  win_len,
  input  logic [31:0]       counter_val,
  output logic              clr_counter,
  output logic [4:0]        px_addr,
  output logic [NPIX-1:0]   stop_osc,
  output logic [31:0]       rd_data,
  output logic              rd_valid,
  input  logic              rd_ack,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  localparam logic [NPIX-1:0]  AllOnes  = {NPIX{1'b1}};
  localparam logic [NPIX-1:0]  OneHot0  = 1;
  localparam logic [WIN_W-1:0] WinOne   = 1;
  localparam logic [4:0]       LastPix  = 5'(NPIX - 1);
  localparam logic [PtrW-1:0]  PtrOne   = 1;
  localparam logic [PtrW:0]    CntOne   = 1;
  localparam logic [PtrW:0]    DepthCnt = FIFO_DEPTH[PtrW:0];

  typedef enum logic [2:0] {StIdle, StClr, StRun, StSettle, StCapt, StNext} state_e;

  state_e           state_q;
  logic [WIN_W-1:0] win_cnt_q;
  logic             settle_q;

  logic [31:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;

  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [WIN_W-1:0] win_load;
  logic [31:0]      capt_word;

  // Window of zero behaves as a single-cycle window.
  assign win_load = (win_len == '0) ? WinOne : win_len;

`ifdef PX_TAG_EN
  assign capt_word = {3'b000, px_addr, counter_val[23:0]};
`else
  assign capt_word = counter_val;
`endif

  // FIFO status and handshake; a pop frees a slot for a same-cycle push.
  assign rd_valid  = (count_q != '0);
  assign fifo_full = (count_q == DepthCnt);
  assign pop       = rd_ack && rd_valid;
  assign push      = (state_q == StCapt) && (!fifo_full || pop);
  assign rd_data   = rd_valid ? mem_q[rd_ptr_q] : 32'h0;

  // Scan FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      win_cnt_q   <= '0;
      settle_q    <= 1'b0;
      px_addr     <= 5'd0;
      stop_osc    <= AllOnes;
      clr_counter <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done        <= 1'b0;
      clr_counter <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q     <= StClr;
            px_addr     <= 5'd0;
            overflow    <= 1'b0;
            clr_counter <= 1'b1;
            busy        <= 1'b1;
          end
        end
        StClr: begin
          win_cnt_q <= win_load;
          stop_osc  <= AllOnes ^ (OneHot0 << px_addr);
          state_q   <= StRun;
        end
        StRun: begin
          if (win_cnt_q <= WinOne) begin
            stop_osc <= AllOnes;
            settle_q <= 1'b0;
            state_q  <= StSettle;
          end else begin
            win_cnt_q <= win_cnt_q - WinOne;
          end
        end
        StSettle: begin
          if (settle_q) begin
            state_q <= StCapt;
          end else begin
            settle_q <= 1'b1;
          end
        end
        StCapt: begin
          if (fifo_full && !rd_ack) begin
            overflow <= 1'b1;
          end
          state_q <= StNext;
        end
        StNext: begin
          if (px_addr == LastPix) begin
            state_q <= StIdle;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            px_addr     <= px_addr + 5'd1;
            clr_counter <= 1'b1;
            state_q     <= StClr;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      if (push && !pop) begin
        count_q <= count_q + CntOne;
      end else if (pop && !push) begin
        count_q <= count_q - CntOne;
      end
    end
  end

  // FIFO storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= capt_word;
    end
  end

endmodule
